// File: rtl/ifmap_pkg.sv
// Shared types and constants for the ifmap loader and the later router packetizer.
// Holds the loader state enum, default geometry, and 33-bit router packet field positions.
// No logic; imported by the loader RTL.
package ifmap_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LSTART  = 3'd1,
    S_WAIT_IN = 3'd2,
    S_SEND_TS = 3'd3,
    S_SEND_AD = 3'd4,
    S_SEND_DT = 3'd5,
    S_LDONE   = 3'd6
  } state_t;

  localparam int DEPTH_I_DEFAULT = 25;
  localparam int NUM_TS_DEFAULT  = 2;

  // Router packet layout, reserved for packetizing the replayed stream later.
  localparam int PKT_WIDTH     = 33;
  localparam int PKT_ADDR_HI   = 32;
  localparam int PKT_ADDR_LO   = 29;
  localparam int PKT_OPCODE_HI = 28;
  localparam int PKT_OPCODE_LO = 25;
  localparam int PKT_DATA_HI   = 24;
  localparam int PKT_DATA_LO   = 0;

endpackage

// File: rtl/ifmap_loader_if.sv
// Handshake bundle between the ifmap loader, its spike source and the IMEM load port.
// Channels: in (spike stream), ls (load start), ts/ad/dt (pixel triple), ld (load done).
// master = loader side, slave = environment side (source + IMEM).
interface ifmap_loader_if #(
  parameter int WIDTH_addr = 12,
  parameter int WIDTH_ts   = 2
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_spike;

  logic                  ls_valid;
  logic                  ls_ready;
  logic                  ls_data;

  logic                  ts_valid;
  logic                  ts_ready;
  logic [WIDTH_ts-1:0]   ts_data;

  logic                  ad_valid;
  logic                  ad_ready;
  logic [WIDTH_addr-1:0] ad_data;

  logic                  dt_valid;
  logic                  dt_ready;
  logic                  dt_data;

  logic                  ld_valid;
  logic                  ld_ready;
  logic                  ld_data;

  modport master (
    input  in_valid, in_spike,
    input  ls_ready, ts_ready, ad_ready, dt_ready, ld_ready,
    output in_ready,
    output ls_valid, ls_data,
    output ts_valid, ts_data,
    output ad_valid, ad_data,
    output dt_valid, dt_data,
    output ld_valid, ld_data
  );

  modport slave (
    output in_valid, in_spike,
    output ls_ready, ts_ready, ad_ready, dt_ready, ld_ready,
    input  in_ready,
    input  ls_valid, ls_data,
    input  ts_valid, ts_data,
    input  ad_valid, ad_data,
    input  dt_valid, dt_data,
    input  ld_valid, ld_data
  );

endinterface

// File: rtl/ifmap_loader.sv
// Replays a flat spike stream onto IMEM's load port: ls token, (ts, addr, spike) per pixel, ld token.
// Latency: 4 cycles per pixel minimum, 1 + 4*NUM_TS*DEPTH_I^2 + 1 cycles per load.
// Backpressure: any ready low (or in_valid low) stalls in the current state; nothing dropped.
// Ports: i_clk, i_reset (sync, active-high), i_start (sampled in IDLE only),
//        o_busy (accepted start .. ld transfer), bus (ifmap_loader_if.master, all channels).
// Geometry limits: DEPTH_I^2 <= 2^WIDTH_addr, NUM_TS <= 2^WIDTH_ts - 1.
module ifmap_loader
  import ifmap_pkg::*;
#(
  parameter int DEPTH_I    = DEPTH_I_DEFAULT,
  parameter int NUM_TS     = NUM_TS_DEFAULT,
  parameter int WIDTH_addr = 12,
  parameter int WIDTH_ts   = 2
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  output logic           o_busy,
  ifmap_loader_if.master bus
);

  localparam int                    NUM_PIX   = DEPTH_I * DEPTH_I;
  localparam logic [WIDTH_addr-1:0] LAST_ADDR = WIDTH_addr'(NUM_PIX - 1);
  localparam logic [WIDTH_ts-1:0]   FIRST_TS  = WIDTH_ts'(1);
  localparam logic [WIDTH_ts-1:0]   LAST_TS   = WIDTH_ts'(NUM_TS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH_addr-1:0] r_addr;
  logic [WIDTH_ts-1:0]   r_ts;
  logic                  r_spike;

  logic w_load_begin;
  logic w_in_fire;
  logic w_dt_fire;
  logic w_last_addr;
  logic w_last_pix;

  assign w_load_begin = (r_state == S_IDLE) && i_start;
  assign w_in_fire    = (r_state == S_WAIT_IN) && bus.in_valid;
  assign w_dt_fire    = (r_state == S_SEND_DT) && bus.dt_ready;
  assign w_last_addr  = (r_addr == LAST_ADDR);
  assign w_last_pix   = w_last_addr && (r_ts == LAST_TS);

  // Data channels present the counters and the latched spike directly, so
  // they stay stable for as long as the matching valid is held.
  assign bus.ts_data = r_ts;
  assign bus.ad_data = r_addr;
  assign bus.dt_data = r_spike;
  assign bus.ls_data = 1'b1;
  assign bus.ld_data = 1'b1;

  // Busy is a pure state decode: rises the cycle after start is taken and
  // drops the cycle after the ld transfer returns the FSM to IDLE.
  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Valids and in_ready depend only on r_state; readies only steer the next state.
  always_comb begin
    w_state_nxt  = r_state;
    bus.in_ready = 1'b0;
    bus.ls_valid = 1'b0;
    bus.ts_valid = 1'b0;
    bus.ad_valid = 1'b0;
    bus.dt_valid = 1'b0;
    bus.ld_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_LSTART;
      end
      S_LSTART: begin
        bus.ls_valid = 1'b1;
        if (bus.ls_ready) w_state_nxt = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_SEND_TS;
      end
      S_SEND_TS: begin
        bus.ts_valid = 1'b1;
        if (bus.ts_ready) w_state_nxt = S_SEND_AD;
      end
      S_SEND_AD: begin
        bus.ad_valid = 1'b1;
        if (bus.ad_ready) w_state_nxt = S_SEND_DT;
      end
      S_SEND_DT: begin
        bus.dt_valid = 1'b1;
        if (bus.dt_ready) w_state_nxt = w_last_pix ? S_LDONE : S_WAIT_IN;
      end
      S_LDONE: begin
        bus.ld_valid = 1'b1;
        if (bus.ld_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pixel counters. On the final pixel they hold rather than wrap so the
  // timestep field never overflows its width between loads.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr  <= '0;
      r_ts    <= FIRST_TS;
      r_spike <= 1'b0;
    end else begin
      if (w_load_begin) begin
        r_addr <= '0;
        r_ts   <= FIRST_TS;
      end else if (w_dt_fire && !w_last_pix) begin
        if (w_last_addr) begin
          r_addr <= '0;
          r_ts   <= r_ts + 1'b1;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
      if (w_in_fire) r_spike <= bus.in_spike;
    end
  end

endmodule

// File: tb/tb_ifmap_loader.sv
`timescale 1ns/1ps
module tb_ifmap_loader;

  localparam int DI   = 25;
  localparam int NT   = 2;
  localparam int WA   = 12;
  localparam int WT   = 2;
  localparam int NPIX = DI * DI;
  localparam int NTOT = NPIX * NT;

  localparam int K_LS = 0;
  localparam int K_TS = 1;
  localparam int K_AD = 2;
  localparam int K_DT = 3;
  localparam int K_LD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  ifmap_loader_if #(.WIDTH_addr(WA), .WIDTH_ts(WT)) bus ();

  ifmap_loader #(.DEPTH_I(DI), .NUM_TS(NT), .WIDTH_addr(WA), .WIDTH_ts(WT)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .o_busy  (busy),
    .bus     (bus)
  );

  typedef struct {
    int kind;
    int val;
  } tok_t;

  typedef struct {
    bit       start;
    bit       in_v;
    bit       spk;
    bit [4:0] rdy;     // {ls, ts, ad, dt, ld}
    bit [4:0] exp_v;   // {ls, ts, ad, dt, ld}
    bit       exp_in_rdy;
    bit       exp_busy;
    int       exp_ts;
    int       exp_ad;
    int       exp_dt;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  tok_t obs_q[$];
  tok_t exp_q[$];
  bit   spikes[$];
  int   consumed = 0;
  int   onehot_err = 0;
  int   stab_err = 0;

  // Driver knobs
  int mode = 0;
  bit rnd = 0;
  int ts_stall_pix = -1;
  int gap_pix = -1;
  int start_pix = -1;
  int ts_stall_cnt = 0;
  int gap_cnt = 0;
  bit start_done = 0;
  bit start_hold = 0;
  bit ts_stall_now = 0;
  bit gap_now = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the exact token order IMEM must see for one load.
  task automatic build_model();
    tok_t t;
    exp_q.delete();
    t.kind = K_LS; t.val = 1; exp_q.push_back(t);
    for (int ts = 1; ts <= NT; ts++) begin
      for (int a = 0; a < NPIX; a++) begin
        t.kind = K_TS; t.val = ts; exp_q.push_back(t);
        t.kind = K_AD; t.val = a;  exp_q.push_back(t);
        t.kind = K_DT; t.val = int'(spikes[(ts - 1) * NPIX + a]); exp_q.push_back(t);
      end
    end
    t.kind = K_LD; t.val = 1; exp_q.push_back(t);
  endtask

  task automatic compare_stream(input string tag, input bit prefix_only);
    int n;
    int m;
    if (!prefix_only) check({tag, "_len"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    if (prefix_only) check({tag, "_prefix_fits"}, obs_q.size() <= exp_q.size(), 1);
    m = -1;
    for (int i = 0; i < n; i++) begin
      if (m < 0 && (obs_q[i].kind != exp_q[i].kind || obs_q[i].val != exp_q[i].val)) m = i;
    end
    checks++;
    if (m >= 0) begin
      failures++;
      $display("FAIL %s_data: token %0d got kind %0d val %0d expected kind %0d val %0d",
               tag, m, obs_q[m].kind, obs_q[m].val, exp_q[m].kind, exp_q[m].val);
    end
  endtask

  task automatic quiet_inputs();
    start = 0;
    bus.in_valid = 0; bus.in_spike = 0;
    bus.ls_ready = 0; bus.ts_ready = 0; bus.ad_ready = 0; bus.dt_ready = 0; bus.ld_ready = 0;
  endtask

  task automatic do_reset();
    mode = 0;
    @(posedge clk); #1;
    quiet_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic begin_load(input bit use_rnd, input int stall_p, input int gap_p, input int start_p);
    spikes.delete();
    for (int i = 0; i < NTOT; i++) spikes.push_back(use_rnd ? bit'($urandom_range(0, 1)) : (i % 2 == 0));
    build_model();
    obs_q.delete();
    consumed = 0;
    rnd = use_rnd;
    ts_stall_pix = stall_p; gap_pix = gap_p; start_pix = start_p;
    ts_stall_cnt = 0; gap_cnt = 0; start_done = 0; start_hold = 0;
    mode = 1;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy === 1'b1 && cyc < 40000) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_drops"}, busy, 0);
    repeat (3) @(negedge clk);
    mode = 0;
  endtask

  // Source / sink driver: one decision per cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (mode == 1) begin
      ts_stall_now = 0;
      gap_now = 0;
      if (rnd) begin
        bus.ls_ready = ($urandom_range(0, 3) != 0);
        bus.ts_ready = ($urandom_range(0, 3) != 0);
        bus.ad_ready = ($urandom_range(0, 3) != 0);
        bus.dt_ready = ($urandom_range(0, 3) != 0);
        bus.ld_ready = ($urandom_range(0, 3) != 0);
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end else begin
        bus.ls_ready = 1; bus.ts_ready = 1; bus.ad_ready = 1; bus.dt_ready = 1; bus.ld_ready = 1;
        bus.in_valid = 1;
      end
      if (ts_stall_pix >= 0 && bus.ts_valid && bus.ts_data == 2'd1 &&
          int'(bus.ad_data) == ts_stall_pix && ts_stall_cnt < 10) begin
        bus.ts_ready = 0;
        ts_stall_cnt++;
        ts_stall_now = 1;
      end
      if (gap_pix >= 0 && bus.in_ready && consumed == gap_pix && gap_cnt < 20) begin
        bus.in_valid = 0;
        gap_cnt++;
        gap_now = 1;
      end
      bus.in_spike = (consumed < spikes.size()) ? spikes[consumed] : 1'b0;
      if (start_hold) begin
        start = 0;
        start_hold = 0;
      end
      if (start_pix >= 0 && consumed == start_pix && !start_done) begin
        start = 1;
        start_done = 1;
        start_hold = 1;
      end
    end else begin
      ts_stall_now = 0;
      gap_now = 0;
    end
  end

  // Monitor: records every output transfer and watches protocol rules.
  int  pv[5], pr[5], pd[5];
  bit  prev_rst = 1;
  always @(negedge clk) begin
    int   cv[5], cr[5], cd[5];
    int   nv;
    tok_t t;
    cv = '{int'(bus.ls_valid), int'(bus.ts_valid), int'(bus.ad_valid), int'(bus.dt_valid), int'(bus.ld_valid)};
    cr = '{int'(bus.ls_ready), int'(bus.ts_ready), int'(bus.ad_ready), int'(bus.dt_ready), int'(bus.ld_ready)};
    cd = '{int'(bus.ls_data),  int'(bus.ts_data),  int'(bus.ad_data),  int'(bus.dt_data),  int'(bus.ld_data)};
    if (!reset) begin
      nv = 0;
      for (int k = 0; k < 5; k++) begin
        nv += cv[k];
        if (cv[k] != 0 && cr[k] != 0) begin
          t.kind = k; t.val = cd[k];
          obs_q.push_back(t);
        end
        if (!prev_rst && pv[k] != 0 && pr[k] == 0 && (cv[k] == 0 || cd[k] != pd[k])) stab_err++;
      end
      if (nv > 1) onehot_err++;
      if (bus.in_valid && bus.in_ready) consumed++;
      if (ts_stall_now)
        check("ts_stall_hold", {bus.ts_valid, bus.ts_data, bus.ad_valid, bus.ad_data}, {1'b1, 2'd1, 1'b0, 12'd3});
      if (gap_now)
        check("in_gap_quiet", {bus.in_ready, bus.ls_valid, bus.ts_valid, bus.ad_valid, bus.dt_valid, bus.ld_valid},
              6'b100000);
    end
    pv = cv; pr = cr; pd = cd;
    prev_rst = reset;
  end

  vec_t vecs[14];
  int   cyc;
  int   ld_cnt;

  initial begin
    quiet_inputs();

    // Cycle-exact opening of a load: handshake stalls, first two pixels, start ignored while busy.
    //            start inv spk rdy       exp_v     inrdy busy ts ad dt
    vecs[0]  = '{1, 0, 0, 5'b11111, 5'b00000, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 0, 0, 5'b11111, 5'b10000, 0, 1, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 5'b11111, 5'b00000, 1, 1, 1, 0, 0};
    vecs[3]  = '{0, 1, 1, 5'b11111, 5'b00000, 1, 1, 1, 0, 0};
    vecs[4]  = '{0, 0, 0, 5'b10111, 5'b01000, 0, 1, 1, 0, 1};
    vecs[5]  = '{0, 0, 0, 5'b11111, 5'b01000, 0, 1, 1, 0, 1};
    vecs[6]  = '{0, 0, 0, 5'b11011, 5'b00100, 0, 1, 1, 0, 1};
    vecs[7]  = '{0, 0, 0, 5'b11111, 5'b00100, 0, 1, 1, 0, 1};
    vecs[8]  = '{0, 0, 0, 5'b11111, 5'b00010, 0, 1, 1, 0, 1};
    vecs[9]  = '{1, 1, 0, 5'b11111, 5'b00000, 1, 1, 1, 1, 1};
    vecs[10] = '{0, 0, 0, 5'b11111, 5'b01000, 0, 1, 1, 1, 0};
    vecs[11] = '{0, 0, 0, 5'b11111, 5'b00100, 0, 1, 1, 1, 0};
    vecs[12] = '{0, 0, 0, 5'b11111, 5'b00010, 0, 1, 1, 1, 0};
    vecs[13] = '{0, 0, 0, 5'b11111, 5'b00000, 1, 1, 1, 2, 0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      start        = vecs[i].start;
      bus.in_valid = vecs[i].in_v;
      bus.in_spike = vecs[i].spk;
      {bus.ls_ready, bus.ts_ready, bus.ad_ready, bus.dt_ready, bus.ld_ready} = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {bus.ls_valid, bus.ts_valid, bus.ad_valid, bus.dt_valid, bus.ld_valid, bus.in_ready, busy,
             bus.ts_data, bus.ad_data, bus.dt_data, bus.ls_data, bus.ld_data},
            {vecs[i].exp_v, vecs[i].exp_in_rdy, vecs[i].exp_busy,
             2'(vecs[i].exp_ts), 12'(vecs[i].exp_ad), 1'(vecs[i].exp_dt), 2'b11});
    end

    // Full load, all-ready sink, alternating spikes: exact token stream and minimum load time.
    do_reset();
    begin_load(0, -1, -1, -1);
    wait_idle("full", cyc);
    check("full_busy_cycles", cyc, 5002);
    compare_stream("full", 0);
    if (obs_q.size() >= 1 + 3 * 626)
      check("ts_boundary", {obs_q[1 + 3 * 624 + 1].val, obs_q[1 + 3 * 625].val, obs_q[1 + 3 * 625 + 1].val},
            {32'd624, 32'd2, 32'd0});
    else
      check("ts_boundary_present", obs_q.size(), 1 + 3 * 626);

    // Corner load: ts stall on pixel 3, 20-cycle source gap at pixel 50, stray start at pixel 100.
    begin_load(0, 3, 50, 100);
    wait_idle("corner", cyc);
    check("corner_busy_cycles", cyc, 5002 + 10 + 20);
    check("corner_stall_len", ts_stall_cnt, 10);
    check("corner_gap_len", gap_cnt, 20);
    compare_stream("corner", 0);

    // Random load aborted by reset at pixel 700.
    begin_load(1, -1, -1, -1);
    cyc = 0;
    while (consumed < 700 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_pixel700", consumed >= 700, 1);
    mode = 0;
    quiet_inputs();
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("abort_idle",
          {bus.ls_valid, bus.ts_valid, bus.ad_valid, bus.dt_valid, bus.ld_valid, bus.in_ready, busy,
           bus.ts_data, bus.ad_data, bus.dt_data},
          {7'b0000000, 2'd1, 12'd0, 1'b0});
    ld_cnt = 0;
    foreach (obs_q[i]) if (obs_q[i].kind == K_LD) ld_cnt++;
    check("abort_no_ld", ld_cnt, 0);
    compare_stream("abort", 1);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", busy, 0);

    // Fresh random load after the abort must restart at ts=1, addr=0.
    begin_load(1, -1, -1, -1);
    wait_idle("rand", cyc);
    compare_stream("rand", 0);
    if (obs_q.size() >= 3)
      check("restart_first", {obs_q[1].kind, obs_q[1].val, obs_q[2].kind, obs_q[2].val},
            {K_TS, 32'd1, K_AD, 32'd0});
    else
      check("restart_first_present", obs_q.size(), 3);

    check("valid_onehot", onehot_err, 0);
    check("hold_stable", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifmap_loader.md
# ifmap_loader

Clocked sequencer that feeds the input-memory (IMEM) stage of the spiking-network accelerator. It accepts a flat stream of ifmap spike bits for NUM_TS timesteps and replays them onto IMEM's load interface in order: one load-start token, then a (timestep, address, data) triple per pixel, then one load-done token. It lets the IMEM stage be driven from real hardware instead of a file-reading bench, with exactly the ordering IMEM already consumes.

## Interface
- DEPTH_I, 25: ifmap side length; DEPTH_I*DEPTH_I pixels per timestep.
- NUM_TS, 2: timesteps per load.
- WIDTH_addr, 12: address width; DEPTH_I*DEPTH_I must be at most 2^WIDTH_addr.
- WIDTH_ts, 2: timestep field width; NUM_TS must be at most 2^WIDTH_ts - 1.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- in_valid / in_ready / in_spike  in/out/in  1/1/1  spike stream; a beat transfers on valid&ready.
- ls_valid / ls_ready / ls_data  out/in/out  1/1/1  load_start token, value 1.
- ts_valid / ts_ready / ts_data  out/in/out  1/1/WIDTH_ts  timestep of the current pixel, 1-based.
- ad_valid / ad_ready / ad_data  out/in/out  1/1/WIDTH_addr  pixel address within the timestep.
- dt_valid / dt_ready / dt_data  out/in/out  1  spike bit.
- ld_valid / ld_ready / ld_data  out/in/out  1/1/1  load_done token, value 1.
- busy  out  1  high from the accepted start until the load_done transfer.

## Operation
- States:
  - IDLE: start=1 goes to LSTART.
  - LSTART: ls_valid=1; on ls_ready goes to WAIT_IN.
  - WAIT_IN: in_ready=1; on in_valid, latch in_spike and go to SEND_TS.
  - SEND_TS: on ts_ready go to SEND_AD.
  - SEND_AD: on ad_ready go to SEND_DT.
  - SEND_DT: on dt_ready go to WAIT_IN, or to LDONE after the final pixel.
  - LDONE: ld_valid=1; on ld_ready goes to IDLE.
- Each valid is high only in its own state. Data is held stable while valid is high. Only one output channel is valid at a time.
- Counters:
  - addr counts 0..DEPTH_I²-1 and advances after each DT transfer.
  - ts starts at 1 and increments when addr wraps from DEPTH_I²-1 to 0.
  - The final pixel is addr=DEPTH_I²-1 with ts=NUM_TS.
- On leaving IDLE, addr is set to 0 and ts to 1.
- start while busy is ignored and is not queued.
- in_ready is low outside WAIT_IN. The source must hold in_spike with in_valid.

## Timing
- Reset values:
  - state IDLE; every valid, in_ready and busy are 0.
  - ts_data=1, ad_data=0, dt_data=0; ls_data and ld_data are constant 1.
- Valids and in_ready are decoded from registered state, so there is no combinational path from any ready to any valid. A state is exited on the edge where its handshake fires.
- busy rises the cycle after start is sampled and falls the cycle after the ld transfer.
- Minimum throughput is 4 cycles per pixel (WAIT_IN, TS, AD, DT), with all readies and in_valid held high.
- Minimum total load time is 1 + 4·NUM_TS·DEPTH_I² + 1 cycles after start. With defaults this is 5002 cycles.
- Ready low stalls indefinitely in the current state; nothing is dropped or reordered.
- Reset asserted mid-load returns to IDLE on the next edge with all valids low. No load_done is issued for an aborted load.

## Structure
- Shared package ifmap_pkg holds:
  - the state enum;
  - DEPTH_I and NUM_TS defaults;
  - the 33-bit router packet field constants (ADDR 32:29, OPCODE 28:25, DATA 24:0), for later packetization.
- Single module with no sub-modules. The FSM and the two counters fit comfortably in one block.

## Test plan
- Reset, then start with an all-ready sink and spikes alternating 1,0:
  - required: one ls token;
  - then 1250 triples (ts=1 for addr 0..624, ts=2 for addr 0..624, data alternating);
  - then one ld token;
  - busy low 5002 cycles after start.
- ts_ready held low for 10 cycles on pixel 3: FSM stays in SEND_TS, ts_data=1 and ad_valid=0 throughout, then the sequence resumes unchanged.
- Timestep boundary: at addr=624, ts=1, the next triple carries ts=2, addr=0.
- start pulsed at pixel 100 during a load: no effect; exactly one ls and one ld for the whole load.
- reset asserted at pixel 700: the next cycle has every valid low and state IDLE; a new start restarts at ts=1, addr=0.
- in_valid low for 20 cycles in WAIT_IN: no output valids during the gap; spike order is preserved.
